// File: rtl/ctrl_unit.sv
// Single-cycle MIPS-subset control unit: combinational opcode/func decode
// captured into one register bank, so every control output has 1-cycle latency.
module ctrl_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       z,
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       sext,
  output logic       regrt,
  output logic       jal,
  output logic       wreg,
  output logic       alium,
  output logic       wmen,
  output logic [3:0] aluc,
  output logic       shift,
  output logic [1:0] prsource,
  output logic       m2reg
);

  localparam int unsigned ALUC_W = 4;
  localparam int unsigned PCS_W  = 2;

  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALU_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SRA = 4'b1111;

  localparam logic [PCS_W-1:0] PC_SEQ = 2'b00;
  localparam logic [PCS_W-1:0] PC_BR  = 2'b01;
  localparam logic [PCS_W-1:0] PC_REG = 2'b10;
  localparam logic [PCS_W-1:0] PC_JMP = 2'b11;

  typedef struct packed {
    logic              sext;
    logic              regrt;
    logic              jal;
    logic              wreg;
    logic              alium;
    logic              wmen;
    logic [ALUC_W-1:0] aluc;
    logic              shift;
    logic [PCS_W-1:0]  prsource;
    logic              m2reg;
  } ctrl_t;

  ctrl_t dec_c;
  ctrl_t ctrl_q;

  // Decode; anything not matched leaves the all-zero (no write, PC+4) word.
  always_comb begin
    dec_c = '0;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin dec_c.wreg = 1'b1; dec_c.aluc = ALU_ADD; end
          6'b100010: begin dec_c.wreg = 1'b1; dec_c.aluc = ALU_SUB; end
          6'b100100: begin dec_c.wreg = 1'b1; dec_c.aluc = ALU_AND; end
          6'b100101: begin dec_c.wreg = 1'b1; dec_c.aluc = ALU_OR;  end
          6'b100110: begin dec_c.wreg = 1'b1; dec_c.aluc = ALU_XOR; end
          6'b000000: begin dec_c.wreg = 1'b1; dec_c.shift = 1'b1; dec_c.aluc = ALU_SLL; end
          6'b000010: begin dec_c.wreg = 1'b1; dec_c.shift = 1'b1; dec_c.aluc = ALU_SRL; end
          6'b000011: begin dec_c.wreg = 1'b1; dec_c.shift = 1'b1; dec_c.aluc = ALU_SRA; end
          6'b001000: dec_c.prsource = PC_REG;
          default:   dec_c = '0;
        endcase
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec_c.wreg  = 1'b1;
        dec_c.regrt = 1'b1;
        dec_c.alium = 1'b1;
        case (op[2:0])
          3'b000:  begin dec_c.sext = 1'b1; dec_c.aluc = ALU_ADD; end
          3'b100:  dec_c.aluc = ALU_AND;
          3'b101:  dec_c.aluc = ALU_OR;
          3'b110:  dec_c.aluc = ALU_XOR;
          default: dec_c.aluc = ALU_LUI;
        endcase
      end
      6'b100011: begin
        dec_c.wreg  = 1'b1;
        dec_c.regrt = 1'b1;
        dec_c.alium = 1'b1;
        dec_c.sext  = 1'b1;
        dec_c.m2reg = 1'b1;
        dec_c.aluc  = ALU_ADD;
      end
      6'b101011: begin
        dec_c.wmen  = 1'b1;
        dec_c.alium = 1'b1;
        dec_c.sext  = 1'b1;
        dec_c.aluc  = ALU_ADD;
      end
      6'b000100: begin
        dec_c.sext     = 1'b1;
        dec_c.aluc     = ALU_SUB;
        dec_c.prsource = z ? PC_BR : PC_SEQ;
      end
      6'b000101: begin
        dec_c.sext     = 1'b1;
        dec_c.aluc     = ALU_SUB;
        dec_c.prsource = z ? PC_SEQ : PC_BR;
      end
      6'b000010: dec_c.prsource = PC_JMP;
      6'b000011: begin
        dec_c.prsource = PC_JMP;
        dec_c.jal      = 1'b1;
        dec_c.wreg     = 1'b1;
      end
      default: dec_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= dec_c;
  end

  assign sext     = ctrl_q.sext;
  assign regrt    = ctrl_q.regrt;
  assign jal      = ctrl_q.jal;
  assign wreg     = ctrl_q.wreg;
  assign alium    = ctrl_q.alium;
  assign wmen     = ctrl_q.wmen;
  assign aluc     = ctrl_q.aluc;
  assign shift    = ctrl_q.shift;
  assign prsource = ctrl_q.prsource;
  assign m2reg    = ctrl_q.m2reg;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: expected control words are queued as each
// instruction is driven and popped when the registered outputs appear.
module tb_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       z;
  logic [5:0] op;
  logic [5:0] func;
  logic       sext, regrt, jal, wreg, alium, wmen, shift, m2reg;
  logic [3:0] aluc;
  logic [1:0] prsource;

  int checks;
  int errors;
  logic [14:0] sb_q[$];

  ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .z(z), .op(op), .func(func),
    .sext(sext), .regrt(regrt), .jal(jal), .wreg(wreg), .alium(alium),
    .wmen(wmen), .aluc(aluc), .shift(shift), .prsource(prsource), .m2reg(m2reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: sext regrt jal wreg alium wmen aluc shift prsource m2reg
  function automatic logic [14:0] mk(input logic s, input logic rt, input logic j,
                                     input logic w, input logic ai, input logic wm,
                                     input logic [3:0] a, input logic sh,
                                     input logic [1:0] pc, input logic m2);
    return {s, rt, j, w, ai, wm, a, sh, pc, m2};
  endfunction

  function automatic logic [14:0] observed();
    return {sext, regrt, jal, wreg, alium, wmen, aluc, shift, prsource, m2reg};
  endfunction

  task automatic check(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one instruction, push its expectation, check after the next edge.
  task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic zz, input logic [14:0] exp);
    logic [14:0] e;
    @(negedge clk);
    op = o; func = f; z = zz;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; z = 1'b0; op = 6'b100011; func = 6'b000000;
    #2;
    check("reset_initial", 15'd0);
    @(posedge clk); #1;
    check("reset_hold", 15'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("r_add", 6'b000000, 6'b100000, 1'b0, mk(0,0,0,1,0,0,4'b0000,0,2'b00,0));
    step("r_sub", 6'b000000, 6'b100010, 1'b0, mk(0,0,0,1,0,0,4'b0100,0,2'b00,0));
    step("r_and", 6'b000000, 6'b100100, 1'b1, mk(0,0,0,1,0,0,4'b0001,0,2'b00,0));
    step("r_or",  6'b000000, 6'b100101, 1'b0, mk(0,0,0,1,0,0,4'b0101,0,2'b00,0));
    step("r_xor", 6'b000000, 6'b100110, 1'b0, mk(0,0,0,1,0,0,4'b0010,0,2'b00,0));
    step("r_sll", 6'b000000, 6'b000000, 1'b0, mk(0,0,0,1,0,0,4'b0011,1,2'b00,0));
    step("r_srl", 6'b000000, 6'b000010, 1'b0, mk(0,0,0,1,0,0,4'b0111,1,2'b00,0));
    step("r_sra", 6'b000000, 6'b000011, 1'b0, mk(0,0,0,1,0,0,4'b1111,1,2'b00,0));
    step("r_jr",  6'b000000, 6'b001000, 1'b0, mk(0,0,0,0,0,0,4'b0000,0,2'b10,0));
    step("r_bad_func", 6'b000000, 6'b100001, 1'b0, 15'd0);
    step("addi", 6'b001000, 6'b111111, 1'b0, mk(1,1,0,1,1,0,4'b0000,0,2'b00,0));
    step("andi", 6'b001100, 6'b000000, 1'b0, mk(0,1,0,1,1,0,4'b0001,0,2'b00,0));
    step("ori",  6'b001101, 6'b000000, 1'b0, mk(0,1,0,1,1,0,4'b0101,0,2'b00,0));
    step("xori", 6'b001110, 6'b000000, 1'b0, mk(0,1,0,1,1,0,4'b0010,0,2'b00,0));
    step("lui",  6'b001111, 6'b000000, 1'b0, mk(0,1,0,1,1,0,4'b0110,0,2'b00,0));
    step("lw",   6'b100011, 6'b000000, 1'b0, mk(1,1,0,1,1,0,4'b0000,0,2'b00,1));
    step("sw",   6'b101011, 6'b000000, 1'b0, mk(1,0,0,0,1,1,4'b0000,0,2'b00,0));
    step("beq_z1", 6'b000100, 6'b000000, 1'b1, mk(1,0,0,0,0,0,4'b0100,0,2'b01,0));
    step("beq_z0", 6'b000100, 6'b000000, 1'b0, mk(1,0,0,0,0,0,4'b0100,0,2'b00,0));
    step("bne_z0", 6'b000101, 6'b000000, 1'b0, mk(1,0,0,0,0,0,4'b0100,0,2'b01,0));
    step("bne_z1", 6'b000101, 6'b000000, 1'b1, mk(1,0,0,0,0,0,4'b0100,0,2'b00,0));
    step("j",    6'b000010, 6'b000000, 1'b0, mk(0,0,0,0,0,0,4'b0000,0,2'b11,0));
    step("jal",  6'b000011, 6'b000000, 1'b0, mk(0,0,1,1,0,0,4'b0000,0,2'b11,0));
    step("bad_op", 6'b111111, 6'b100000, 1'b1, 15'd0);

    // Input changes late in the cycle: only the value present at the edge counts.
    @(negedge clk);
    op = 6'b000010; func = 6'b000000; z = 1'b0;
    #1;
    check("midcycle_no_change", 15'd0);
    #2;
    op = 6'b100011;
    sb_q.push_back(mk(1,1,0,1,1,0,4'b0000,0,2'b00,1));
    @(posedge clk); #1;
    if (sb_q.size() != 0) check("midcycle_lw", sb_q.pop_front());

    // Reset asserted mid-cycle clears outputs with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 15'd0);
    @(posedge clk); #1;
    check("reset_hold_lw", 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_lw", 6'b100011, 6'b000000, 1'b0, mk(1,1,0,1,1,0,4'b0000,0,2'b00,1));

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock; all outputs are registered on it.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 z  input  1  ALU zero flag for the current instruction.
REQ-005 op  input  6  instruction opcode field [31:26].
REQ-006 func  input  6  R-type function field [5:0].
REQ-007 sext  output  1  immediate sign-extend (1) vs zero-extend (0).
REQ-008 regrt  output  1  destination register is rt (1) vs rd (0).
REQ-009 jal  output  1  write PC+4 to $31.
REQ-010 wreg  output  1  register-file write enable.
REQ-011 alium  output  1  ALU B operand is the immediate.
REQ-012 wmen  output  1  data-memory write enable.
REQ-013 aluc  output  4  ALU operation code.
REQ-014 shift  output  1  ALU A operand is the shamt field.
REQ-015 prsource  output  2  next-PC select: 00 PC+4, 01 branch target, 10 register (jr), 11 jump target.
REQ-016 m2reg  output  1  register write data comes from memory.

Function
REQ-017 Decode SHALL be combinational from op, func and z; every output SHALL be registered at the rising clk edge, giving 1-cycle latency.
REQ-018 aluc encoding SHALL be: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
REQ-019 R-type (op=000000) with func add 100000, sub 100010, and 100100, or 100101, xor 100110 SHALL give wreg=1, the matching aluc, and all other outputs 0.
REQ-020 R-type shifts with func sll 000000, srl 000010, sra 000011 SHALL give wreg=1, shift=1, the matching aluc, and all other outputs 0.
REQ-021 R-type jr (func 001000) SHALL give prsource=10 and all other outputs 0.
REQ-022 addi 001000 SHALL give wreg=1, regrt=1, alium=1, sext=1, aluc=0000.
REQ-023 andi 001100, ori 001101 and xori 001110 SHALL give wreg=1, regrt=1, alium=1, sext=0, and aluc and/or/xor respectively.
REQ-024 lui 001111 SHALL give wreg=1, regrt=1, alium=1, sext=0, aluc=0110.
REQ-025 lw 100011 SHALL give wreg=1, regrt=1, alium=1, sext=1, m2reg=1, aluc=0000.
REQ-026 sw 101011 SHALL give wmen=1, alium=1, sext=1, aluc=0000, wreg=0.
REQ-027 beq 000100 SHALL give sext=1, aluc=0100, and prsource=01 when z=1 or 00 when z=0; wreg=0.
REQ-028 bne 000101 SHALL give sext=1, aluc=0100, and prsource=01 when z=0 or 00 when z=1; wreg=0.
REQ-029 j 000010 SHALL give prsource=11 and all other outputs 0.
REQ-030 jal 000011 SHALL give prsource=11, jal=1, wreg=1, and all other outputs 0.
REQ-031 Any unlisted op, or an unlisted func with op=000000, SHALL register all outputs as 0, so that no write occurs and the PC selects PC+4.
REQ-032 Any output not named for an instruction SHALL be 0 for that instruction.
REQ-033 Inputs that change mid-cycle SHALL affect only the value captured at the next rising edge.

Reset
REQ-034 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk, and SHALL stay 0.
REQ-035 After rst_n deasserts, the first rising edge SHALL capture the decode of the current inputs.

Verification
REQ-036 rst_n=0 asserted mid-cycle with op=100011 -> all outputs 0 at once, before any clk edge.
REQ-037 op=000000, func=100000, one edge -> wreg=1, aluc=0000, regrt=0, shift=0, prsource=00, others 0.
REQ-038 op=000000, func=000011 -> wreg=1, shift=1, aluc=1111; then func=001000 -> prsource=10, wreg=0.
REQ-039 op=000100 with z=1 -> prsource=01, aluc=0100; then z=0 -> prsource=00; op=000101 with z=0 -> prsource=01.
REQ-040 op=100011 -> wreg=1, regrt=1, alium=1, sext=1, m2reg=1; op=101011 -> wmen=1, wreg=0, m2reg=0.
REQ-041 op=000011 -> jal=1, wreg=1, prsource=11; op=111111 -> all outputs 0.
